// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit RISC core: fetch, decode, execute,
// memory and writeback sequencing with a bus-timeout watchdog on mem_req.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        mem_ack,
  input  logic        rd_zero,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        addr_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        imm_5or8,
  output logic        alu_src_b,
  output logic [2:0]  alu_op,
  output logic        rf_we,
  output logic        rf_wsel,
  output logic        halted,
  output logic [1:0]  err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;

  logic [4:0] opcode;
  logic is_nop, is_add, is_sub, is_and, is_or, is_addi, is_ldi;
  logic is_lw, is_sw, is_beqz, is_jmp, is_halt, is_legal;
  logic unused_instr_bits;

  assign opcode  = instr[15:11];
  assign is_nop  = (opcode == 5'b00000);
  assign is_add  = (opcode == 5'b00001);
  assign is_sub  = (opcode == 5'b00010);
  assign is_and  = (opcode == 5'b00011);
  assign is_or   = (opcode == 5'b00100);
  assign is_addi = (opcode == 5'b00101);
  assign is_ldi  = (opcode == 5'b00110);
  assign is_lw   = (opcode == 5'b00111);
  assign is_sw   = (opcode == 5'b01000);
  assign is_beqz = (opcode == 5'b01001);
  assign is_jmp  = (opcode == 5'b01010);
  assign is_halt = (opcode == 5'b11111);
  assign is_legal = is_nop | is_add | is_sub | is_and | is_or | is_addi | is_ldi |
                    is_lw | is_sw | is_beqz | is_jmp | is_halt;
  assign unused_instr_bits = ^instr[10:0];

  logic       ir_we_c, pc_we_c, addr_sel_c, mem_req_c, mem_we_c;
  logic       imm_c, src_b_c, rf_we_c, rf_wsel_c, halted_c;
  logic [1:0] pc_src_c;
  logic [2:0] alu_op_c;
  logic       timeout;

  // Last permitted wait cycle: without an ack now the request has expired.
  assign timeout = (cnt_q == TIMEOUT_LAST) && !mem_ack;

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_src_c   = 2'd0;
    addr_sel_c = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    imm_c      = 1'b0;
    src_b_c    = 1'b0;
    alu_op_c   = 3'd0;
    rf_we_c    = 1'b0;
    rf_wsel_c  = 1'b0;
    halted_c   = 1'b0;

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      imm_c   = is_ldi | is_beqz | is_jmp;
      src_b_c = is_addi | is_ldi | is_lw | is_sw;
      if (is_sub)      alu_op_c = 3'd1;
      else if (is_and) alu_op_c = 3'd2;
      else if (is_or)  alu_op_c = 3'd3;
      else if (is_ldi) alu_op_c = 3'd4;
      else             alu_op_c = 3'd0;
    end

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ack) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          err_d   = 2'd2;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        if (is_nop) begin
          state_d = S_FETCH;
        end else if (is_halt) begin
          err_d   = 2'd0;
          state_d = S_HALT;
        end else if (!is_legal) begin
          err_d   = 2'd1;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beqz) begin
          pc_we_c  = rd_zero;
          pc_src_c = 2'd1;
          state_d  = S_FETCH;
        end else if (is_jmp) begin
          pc_we_c  = 1'b1;
          pc_src_c = 2'd2;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d  = S_MEM;
        end else begin
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = is_sw;
        if (mem_ack) begin
          state_d = is_sw ? S_FETCH : S_WB;
        end else if (timeout) begin
          err_d   = 2'd2;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        rf_we_c   = 1'b1;
        rf_wsel_c = is_lw;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Only request cycles without ack accumulate; everything else clears.
    if (mem_req_c && !mem_ack && state_d != S_HALT) cnt_d = cnt_q + 1'b1;
    else                                            cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Gating with rst_n forces outputs low the instant reset asserts.
  assign ir_we     = ir_we_c    & rst_n;
  assign pc_we     = pc_we_c    & rst_n;
  assign pc_src    = pc_src_c   & {2{rst_n}};
  assign addr_sel  = addr_sel_c & rst_n;
  assign mem_req   = mem_req_c  & rst_n;
  assign mem_we    = mem_we_c   & rst_n;
  assign imm_5or8  = imm_c      & rst_n;
  assign alu_src_b = src_b_c    & rst_n;
  assign alu_op    = alu_op_c   & {3{rst_n}};
  assign rf_we     = rf_we_c    & rst_n;
  assign rf_wsel   = rf_wsel_c  & rst_n;
  assign halted    = halted_c   & rst_n;
  assign err       = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction vector table plus
// hand-written sequences for wait states, timeout, halt and mid-cycle reset.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        mem_ack;
  logic        rd_zero;
  logic        ir_we, pc_we, addr_sel, mem_req, mem_we;
  logic        imm_5or8, alu_src_b, rf_we, rf_wsel, halted;
  logic [1:0]  pc_src, err;
  logic [2:0]  alu_op, state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ack(mem_ack), .rd_zero(rd_zero),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .addr_sel(addr_sel),
    .mem_req(mem_req), .mem_we(mem_we), .imm_5or8(imm_5or8), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .rf_we(rf_we), .rf_wsel(rf_wsel), .halted(halted),
    .err(err), .state(state)
  );

  typedef struct {
    logic [15:0] instr;
    logic        rdz;
    int          cycles;
    int          imm;
    int          srcb;
    int          op;
    int          epcwe;
    int          epcsrc;
    int          rfwe;
    int          rfwsel;
    int          memwe;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic ack);
    @(negedge clk);
    mem_ack = ack;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    rd_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  cycles, n_rfwe, n_irwe, n_pcwe;
    int  c_imm, c_src, c_op, c_pcwe, c_pcsrc, c_rfwsel, c_memwe;
    bit  done;
    cycles = 0; n_rfwe = 0; n_irwe = 0; n_pcwe = 0; done = 1'b0;
    c_imm = 0; c_src = 0; c_op = 0; c_pcwe = 0; c_pcsrc = 0; c_rfwsel = 0; c_memwe = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      instr   = v.instr;
      rd_zero = v.rdz;
      mem_ack = 1'b1;
      #1;
      if (state == 3'd2) begin
        c_imm = imm_5or8; c_src = alu_src_b; c_op = alu_op;
        c_pcwe = pc_we;   c_pcsrc = pc_src;
      end
      if (state == 3'd4) c_rfwsel = rf_wsel;
      if (state == 3'd3) c_memwe = mem_we;
      n_rfwe += int'(rf_we);
      n_irwe += int'(ir_we);
      n_pcwe += int'(pc_we);
      cycles++;
      @(posedge clk);
      #1;
      if (state == 3'd0 || state == 3'd5) done = 1'b1;
    end
    chk("vec_done", int'(done), 1);
    chk("vec_cycles", cycles, v.cycles);
    chk("vec_back_to_fetch", int'(state), 0);
    chk("vec_imm_5or8", c_imm, v.imm);
    chk("vec_alu_src_b", c_src, v.srcb);
    chk("vec_alu_op", c_op, v.op);
    chk("vec_exec_pc_we", c_pcwe, v.epcwe);
    chk("vec_exec_pc_src", c_pcsrc, v.epcsrc);
    chk("vec_rf_we_count", n_rfwe, v.rfwe);
    chk("vec_rf_wsel", c_rfwsel, v.rfwsel);
    chk("vec_mem_we", c_memwe, v.memwe);
    chk("vec_ir_we_count", n_irwe, 1);
    chk("vec_pc_we_count", n_pcwe, 1 + v.epcwe);
    $display("vec %0d instr=%h rd_zero=%0d cycles=%0d alu_op=%0d rf_we=%0d",
             idx, v.instr, v.rdz, cycles, c_op, n_rfwe);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    //           instr     rdz  cyc imm src op pcwe pcsrc rfwe wsel memwe
    vecs[0]  = '{16'h2A05, 1'b0, 4, 0, 1, 0, 0, 0, 1, 0, 0}; // ADDI
    vecs[1]  = '{16'h0800, 1'b0, 4, 0, 0, 0, 0, 0, 1, 0, 0}; // ADD
    vecs[2]  = '{16'h1000, 1'b0, 4, 0, 0, 1, 0, 0, 1, 0, 0}; // SUB
    vecs[3]  = '{16'h1800, 1'b0, 4, 0, 0, 2, 0, 0, 1, 0, 0}; // AND
    vecs[4]  = '{16'h2000, 1'b0, 4, 0, 0, 3, 0, 0, 1, 0, 0}; // OR
    vecs[5]  = '{16'h31A5, 1'b0, 4, 1, 1, 4, 0, 0, 1, 0, 0}; // LDI
    vecs[6]  = '{16'h3805, 1'b0, 5, 0, 1, 0, 0, 0, 1, 1, 0}; // LW
    vecs[7]  = '{16'h4000, 1'b0, 4, 0, 1, 0, 0, 0, 0, 0, 1}; // SW
    vecs[8]  = '{16'h4825, 1'b1, 3, 1, 0, 0, 1, 1, 0, 0, 0}; // BEQZ taken
    vecs[9]  = '{16'h4825, 1'b0, 3, 1, 0, 0, 0, 1, 0, 0, 0}; // BEQZ not taken
    vecs[10] = '{16'h5010, 1'b0, 3, 1, 0, 0, 1, 2, 0, 0, 0}; // JMP
    vecs[11] = '{16'h0000, 1'b0, 2, 0, 0, 0, 0, 0, 0, 0, 0}; // NOP

    rst_n = 1'b0; mem_ack = 1'b1; rd_zero = 1'b0; instr = 16'h2A05;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_ir_we", int'(ir_we), 0);
    chk("rst_pc_we", int'(pc_we), 0);
    chk("rst_addr_sel", int'(addr_sel), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_err", int'(err), 0);
    $display("reset state=%0d mem_req=%0d err=%0d", state, mem_req, err);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // LW with three wait cycles in MEM
    do_reset();
    instr = 16'h3805;
    tick(1'b1); chk("lw_fetch_ir_we", int'(ir_we), 1);
    tick(1'b0); chk("lw_decode", int'(state), 1);
    tick(1'b0); chk("lw_exec", int'(state), 2);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      tick(k == 3);
      chk("lw_mem_state", int'(state), 3);
      chk("lw_mem_we", int'(mem_we), 0);
      if (mem_req && addr_sel) n++;
    end
    chk("lw_mem_req_cycles", n, 4);
    tick(1'b0);
    chk("lw_wb_state", int'(state), 4);
    chk("lw_wb_rf_we", int'(rf_we), 1);
    chk("lw_wb_rf_wsel", int'(rf_wsel), 1);
    tick(1'b0); chk("lw_return_fetch", int'(state), 0);
    $display("seq lw_wait mem_req_cycles=%0d", n);

    // Fetch timeout: no ack at all
    do_reset();
    instr = 16'h2A05;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      tick(1'b0);
      n += int'(mem_req);
    end
    chk("to_mem_req_cycles", n, 15);
    tick(1'b0);
    chk("to_state", int'(state), 5);
    chk("to_halted", int'(halted), 1);
    chk("to_err", int'(err), 2);
    chk("to_mem_req_dropped", int'(mem_req), 0);
    $display("seq timeout req_cycles=%0d state=%0d err=%0d", n, state, err);

    // Ack on the final permitted cycle wins
    do_reset();
    for (int k = 0; k < 14; k++) tick(1'b0);
    tick(1'b1);
    chk("ack15_ir_we", int'(ir_we), 1);
    tick(1'b0);
    chk("ack15_decode", int'(state), 1);
    chk("ack15_err", int'(err), 0);
    $display("seq ack_at_limit state=%0d", state);

    // Illegal opcode 10101
    do_reset();
    instr = 16'hA800;
    tick(1'b1); tick(1'b0);
    tick(1'b1);
    chk("ill_state", int'(state), 5);
    chk("ill_err", int'(err), 1);
    chk("ill_halted", int'(halted), 1);
    chk("ill_mem_req", int'(mem_req), 0);
    chk("ill_ir_we", int'(ir_we), 0);
    tick(1'b1);
    chk("ill_stays", int'(state), 5);
    chk("ill_pc_we", int'(pc_we), 0);
    $display("seq illegal state=%0d err=%0d", state, err);

    // HALT instruction
    do_reset();
    instr = 16'hF800;
    tick(1'b1); tick(1'b0);
    tick(1'b1);
    chk("halt_state", int'(state), 5);
    chk("halt_err", int'(err), 0);
    chk("halt_halted", int'(halted), 1);
    chk("halt_ir_we", int'(ir_we), 0);
    $display("seq halt state=%0d err=%0d", state, err);

    // Asynchronous reset while an SW is pending in MEM
    do_reset();
    instr = 16'h4000;
    tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
    chk("sw_mem_state", int'(state), 3);
    chk("sw_mem_req", int'(mem_req), 1);
    chk("sw_mem_we", int'(mem_we), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", int'(mem_req), 0);
    chk("arst_mem_we", int'(mem_we), 0);
    chk("arst_state", int'(state), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("seq async_reset mem_req=%0d state=%0d", mem_req, state);
    run_vec(0, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
